// File: rtl/rd_tag_ctrl_if.sv
// rd_tag_ctrl_if: request, completion and scheduler signals of the read
// tag controller; the tag controller connects through the slave modport.
interface rd_tag_ctrl_if #(
  parameter int ID_W  = 8,
  parameter int TAG_W = 5
);
  logic             alloc_valid;
  logic [ID_W-1:0]  alloc_id;
  logic [9:0]       alloc_len_dw;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cpl_valid;
  logic [9:0]       cpl_tag;
  logic [9:0]       cpl_len_dw;
  logic [2:0]       cpl_status;
  logic             cpl_ready;
  logic             sched_valid;
  logic [ID_W-1:0]  sched_rid;
  logic [1:0]       sched_rresp;
  logic             sched_last;
  logic             sched_ready;
  logic             err_unexp;
  logic [TAG_W:0]   outstanding;

  modport master (
    output alloc_valid, alloc_id, alloc_len_dw,
    output cpl_valid, cpl_tag, cpl_len_dw, cpl_status,
    output sched_ready,
    input  alloc_ready, alloc_tag, cpl_ready,
    input  sched_valid, sched_rid, sched_rresp, sched_last,
    input  err_unexp, outstanding
  );

  modport slave (
    input  alloc_valid, alloc_id, alloc_len_dw,
    input  cpl_valid, cpl_tag, cpl_len_dw, cpl_status,
    input  sched_ready,
    output alloc_ready, alloc_tag, cpl_ready,
    output sched_valid, sched_rid, sched_rresp, sched_last,
    output err_unexp, outstanding
  );
endinterface

// File: rtl/rd_tag_ctrl.sv
// rd_tag_ctrl: read tag allocator and completion scheduler.
// Optional tag timeout is compiled in with RD_TAG_TIMEOUT_EN.
module rd_tag_ctrl #(
  parameter int NUM_TAGS    = 32,
  parameter int ID_W        = 8,
  parameter int TICK_CYCLES = 1024,
  localparam int TAG_W      = $clog2(NUM_TAGS)
) (
  input logic          clk,
  input logic          rst_n,
  rd_tag_ctrl_if.slave bus
);

  if (NUM_TAGS < 2 || TICK_CYCLES < 1) begin : g_bad_cfg
    $error("rd_tag_ctrl: bad parameters");
  end

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [ID_W-1:0]     id_q  [NUM_TAGS];
  logic [ID_W-1:0]     id_d  [NUM_TAGS];
  logic [10:0]         rem_q [NUM_TAGS];
  logic [10:0]         rem_d [NUM_TAGS];

  logic            sv_q, sv_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [1:0]      resp_q, resp_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic [TAG_W:0]  cnt_q, cnt_d;

  logic             alloc_fire, cpl_fire;
  logic             cpl_hit, free_ev;
  logic             stage_free;
  logic [TAG_W-1:0] free_tag, ctag;
  logic [10:0]      alen, clen, crem, rem_new;
  logic             ovr, clast;
  logic [1:0]       cresp;

`ifdef RD_TAG_TIMEOUT_EN
  localparam int PS_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic                tick;
  logic [3:0]          age_q [NUM_TAGS];
  logic [3:0]          age_d [NUM_TAGS];
  logic [NUM_TAGS-1:0] exp_v;
  logic                exp_any;
  logic [TAG_W-1:0]    exp_tag;

  assign tick = (ps_q == PS_W'(TICK_CYCLES - 1));
  assign ps_d = tick ? '0 : ps_q + 1'b1;

  always_comb begin
    exp_tag = '0;
    for (int i = 0; i < NUM_TAGS; i++)
      exp_v[i] = busy_q[i] & (age_q[i] == 4'hF);
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (exp_v[i]) exp_tag = TAG_W'(i);
  end
  assign exp_any = |exp_v;
`endif

  always_comb begin
    free_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--)
      if (!busy_q[i]) free_tag = TAG_W'(i);
  end

  assign stage_free = !sv_q || bus.sched_ready;
  assign bus.alloc_ready = ~&busy_q;
  assign bus.alloc_tag   = free_tag;
`ifdef RD_TAG_TIMEOUT_EN
  assign bus.cpl_ready = stage_free && !exp_any;
`else
  assign bus.cpl_ready = stage_free;
`endif

  assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
  assign cpl_fire   = bus.cpl_valid && bus.cpl_ready;

  // length field 0 encodes 1024 DW
  assign alen = {~|bus.alloc_len_dw, bus.alloc_len_dw};
  assign clen = {~|bus.cpl_len_dw, bus.cpl_len_dw};

  assign ctag    = bus.cpl_tag[TAG_W-1:0];
  assign cpl_hit = (bus.cpl_tag < 10'(NUM_TAGS)) && busy_q[ctag];
  assign crem    = rem_q[ctag];
  assign ovr     = clen > crem;
  assign rem_new = crem - clen;
  assign clast   = (rem_new == '0) || (bus.cpl_status != 3'd0) || ovr;

  always_comb begin
    cresp = 2'b10;
    unique case (1'b1)
      bus.cpl_status == 3'b001:         cresp = 2'b11;
      bus.cpl_status == 3'b000 && !ovr: cresp = 2'b00;
      default:                          cresp = 2'b10;
    endcase
  end

  always_comb begin
    busy_d  = busy_q;
    id_d    = id_q;
    rem_d   = rem_q;
    sv_d    = sv_q && !bus.sched_ready;
    rid_d   = rid_q;
    resp_d  = resp_q;
    last_d  = last_q;
    err_d   = 1'b0;
    free_ev = 1'b0;
`ifdef RD_TAG_TIMEOUT_EN
    age_d = age_q;
    if (tick)
      for (int i = 0; i < NUM_TAGS; i++)
        if (busy_q[i] && age_q[i] != 4'hF)
          age_d[i] = age_q[i] + 4'd1;
`endif
    if (alloc_fire) begin
      busy_d[free_tag] = 1'b1;
      id_d[free_tag]   = bus.alloc_id;
      rem_d[free_tag]  = alen;
`ifdef RD_TAG_TIMEOUT_EN
      age_d[free_tag]  = 4'd0;
`endif
    end
    if (cpl_fire && !cpl_hit) begin
      err_d = 1'b1;
    end else if (cpl_fire) begin
      sv_d   = 1'b1;
      rid_d  = id_q[ctag];
      resp_d = cresp;
      last_d = clast;
      if (clast) begin
        busy_d[ctag] = 1'b0;
        free_ev      = 1'b1;
      end else begin
        rem_d[ctag]  = rem_new;
`ifdef RD_TAG_TIMEOUT_EN
        age_d[ctag]  = 4'd0;
`endif
      end
    end
`ifdef RD_TAG_TIMEOUT_EN
    // cpl_ready is held low while anything is expired, so no clash
    else if (exp_any && stage_free) begin
      sv_d            = 1'b1;
      rid_d           = id_q[exp_tag];
      resp_d          = 2'b10;
      last_d          = 1'b1;
      busy_d[exp_tag] = 1'b0;
      free_ev         = 1'b1;
    end
`endif
  end

  assign cnt_d = cnt_q + (TAG_W+1)'(alloc_fire)
                       - (TAG_W+1)'(free_ev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        id_q[i]  <= '0;
        rem_q[i] <= '0;
      end
      sv_q   <= 1'b0;
      rid_q  <= '0;
      resp_q <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      id_q   <= id_d;
      rem_q  <= rem_d;
      sv_q   <= sv_d;
      rid_q  <= rid_d;
      resp_q <= resp_d;
      last_q <= last_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef RD_TAG_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++)
        age_q[i] <= '0;
    end else begin
      ps_q  <= ps_d;
      age_q <= age_d;
    end
  end
`endif

  assign bus.sched_valid = sv_q;
  assign bus.sched_rid   = rid_q;
  assign bus.sched_rresp = resp_q;
  assign bus.sched_last  = last_q;
  assign bus.err_unexp   = err_q;
  assign bus.outstanding = cnt_q;

endmodule

// File: tb/tb_rd_tag_ctrl.sv
// tb_rd_tag_ctrl: directed and random checks of rd_tag_ctrl against
// a table-level model of tag state and expected scheduler output.
module tb_rd_tag_ctrl;
  localparam int NT = 32;
`ifdef RD_TAG_TIMEOUT_EN
  localparam int TICK = 4;
`else
  localparam int TICK = 1024;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rd_tag_ctrl_if #(.ID_W(8), .TAG_W(5)) bus ();

  rd_tag_ctrl #(
    .NUM_TAGS(NT), .ID_W(8), .TICK_CYCLES(TICK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;

  bit       m_busy [NT];
  int       m_rem  [NT];
  bit [7:0] m_id   [NT];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_free();
    for (int i = 0; i < NT; i++)
      if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NT; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic int m_pick();
    int q[$];
    for (int i = 0; i < NT; i++) if (m_busy[i]) q.push_back(i);
    if (q.size() == 0) return int'($urandom_range(0, 47));
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic m_cpl(input int ct, input int cl, input int cs,
                       output bit xe, output bit xv, output bit [7:0] xr,
                       output bit [1:0] xs, output bit xl);
    int l;
    bit ov;
    xe = 0; xv = 0; xr = 0; xs = 0; xl = 0;
    if (ct >= NT || !m_busy[ct]) begin
      xe = 1;
    end else begin
      l  = (cl == 0) ? 1024 : cl;
      ov = l > m_rem[ct];
      xr = m_id[ct];
      if (cs == 1) xs = 2'b11;
      else if (cs != 0 || ov) xs = 2'b10;
      else xs = 2'b00;
      xl = (l >= m_rem[ct]) || (cs != 0);
      if (xl) m_busy[ct] = 0;
      else m_rem[ct] -= l;
      xv = 1;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NT; i++) begin
      m_busy[i] = 0; m_rem[i] = 0; m_id[i] = 0;
    end
  endtask

  // one cycle with optional alloc and completion, sched_ready high
  task automatic step(input bit da, input bit [7:0] aid, input int al,
                      input bit dc, input int ct, input int cl,
                      input int cs);
    int ft;
    bit xe, xv, xl;
    bit [7:0] xr;
    bit [1:0] xs;
    @(negedge clk);
    bus.alloc_valid  = da;
    bus.alloc_id     = aid;
    bus.alloc_len_dw = 10'(al);
    bus.cpl_valid    = dc;
    bus.cpl_tag      = 10'(ct);
    bus.cpl_len_dw   = 10'(cl);
    bus.cpl_status   = 3'(cs);
    bus.sched_ready  = 1'b1;
    #1;
    ft = m_free();
    chk("alloc_ready", 32'(bus.alloc_ready), 32'(ft >= 0));
    if (ft >= 0) chk("alloc_tag", 32'(bus.alloc_tag), ft);
    chk("cpl_ready", 32'(bus.cpl_ready), 1);
    @(posedge clk);
    xe = 0; xv = 0; xr = 0; xs = 0; xl = 0;
    if (dc) m_cpl(ct, (cl % 1024), cs, xe, xv, xr, xs, xl);
    if (da && ft >= 0) begin
      m_busy[ft] = 1;
      m_id[ft]   = aid;
      m_rem[ft]  = ((al % 1024) == 0) ? 1024 : (al % 1024);
    end
    @(negedge clk);
    bus.alloc_valid = 1'b0;
    bus.cpl_valid   = 1'b0;
    chk("err_unexp", 32'(bus.err_unexp), 32'(xe));
    chk("sched_valid", 32'(bus.sched_valid), 32'(xv));
    if (xv) begin
      chk("sched_rid", 32'(bus.sched_rid), 32'(xr));
      chk("sched_rresp", 32'(bus.sched_rresp), 32'(xs));
      chk("sched_last", 32'(bus.sched_last), 32'(xl));
    end
    chk("outstanding", 32'(bus.outstanding), m_count());
  endtask

  initial begin
    logic [7:0] hold_rid;
    logic [1:0] hold_resp;
    int n;
    bus.alloc_valid = 0; bus.alloc_id = 0; bus.alloc_len_dw = 0;
    bus.cpl_valid = 0; bus.cpl_tag = 0; bus.cpl_len_dw = 0;
    bus.cpl_status = 0; bus.sched_ready = 1;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sched_valid", 32'(bus.sched_valid), 0);
    chk("rst_rid", 32'(bus.sched_rid), 0);
    chk("rst_rresp", 32'(bus.sched_rresp), 0);
    chk("rst_last", 32'(bus.sched_last), 0);
    chk("rst_err", 32'(bus.err_unexp), 0);
    chk("rst_outstanding", 32'(bus.outstanding), 0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("rst_alloc_tag", 32'(bus.alloc_tag), 0);

`ifdef RD_TAG_TIMEOUT_EN
    step(1, 8'h5A, 8, 0, 0, 0, 0);
    n = 0;
    while (!bus.sched_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_seen", 32'(bus.sched_valid), 1);
    chk("to_window", 32'(n >= 50 && n <= 66), 1);
    chk("to_rid", 32'(bus.sched_rid), 32'h5A);
    chk("to_rresp", 32'(bus.sched_rresp), 2);
    chk("to_last", 32'(bus.sched_last), 1);
    chk("to_outstanding", 32'(bus.outstanding), 0);
    m_busy[0] = 0;
    step(0, 0, 0, 1, 0, 4, 0);
`else
    step(1, 8'h11, 8, 0, 0, 0, 0);
    step(1, 8'h22, 8, 0, 0, 0, 0);
    step(1, 8'h33, 8, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 4, 0);
    step(0, 0, 0, 1, 1, 4, 0);
    step(1, 8'h44, 8, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 4, 1);
    step(0, 0, 0, 1, 7, 4, 0);
    step(0, 0, 0, 1, 40, 4, 0);
    step(1, 8'h66, 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 4, 0);
    step(1, 8'h77, 4, 1, 0, 8, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    while (m_free() >= 0) step(1, 8'(m_free() + 8'h80), 8, 0, 0, 0, 0);
    step(1, 8'hEE, 8, 0, 0, 0, 0);

    @(negedge clk);
    bus.sched_ready = 1'b0;
    bus.cpl_valid   = 1'b1;
    bus.cpl_tag     = 10'd5;
    bus.cpl_len_dw  = 10'd0;
    bus.cpl_status  = 3'd0;
    #1;
    chk("bp_cpl_ready0", 32'(bus.cpl_ready), 1);
    @(posedge clk);
    begin
      bit xe, xv, xl;
      bit [7:0] xr;
      bit [1:0] xs;
      m_cpl(5, 0, 0, xe, xv, xr, xs, xl);
      @(negedge clk);
      bus.cpl_tag = 10'd6;
      #1;
      chk("bp_valid", 32'(bus.sched_valid), 1);
      chk("bp_rid", 32'(bus.sched_rid), 32'(xr));
      chk("bp_last", 32'(bus.sched_last), 32'(xl));
      chk("bp_cpl_ready1", 32'(bus.cpl_ready), 0);
    end
    hold_rid  = bus.sched_rid;
    hold_resp = bus.sched_rresp;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.sched_valid), 1);
      chk("bp_hold_rid", 32'(bus.sched_rid), 32'(hold_rid));
      chk("bp_hold_rresp", 32'(bus.sched_rresp), 32'(hold_resp));
      chk("bp_hold_ready", 32'(bus.cpl_ready), 0);
    end
    bus.cpl_valid   = 1'b0;
    bus.sched_ready = 1'b1;
    #1;
    chk("bp_release", 32'(bus.cpl_ready), 1);
    @(negedge clk);
    chk("bp_drained", 32'(bus.sched_valid), 0);
    step(1, 8'h55, 8, 0, 0, 0, 0);

    for (int it = 0; it < 400; it++) begin
      bit da, dc;
      int ct, cl, cs, al;
      da = ($urandom_range(0, 1) == 1);
      dc = ($urandom_range(0, 2) != 0);
      ct = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                       : m_pick();
      cl = ($urandom_range(0, 15) == 0) ? 0
                                        : int'($urandom_range(1, 8));
      cs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 0;
      al = ($urandom_range(0, 15) == 0) ? 0
                                        : int'($urandom_range(1, 16));
      step(da, 8'($urandom), al, dc, ct, cl, cs);
    end

    step(1, 8'h99, 8, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(bus.sched_valid), 0);
    chk("mid_rst_outstanding", 32'(bus.outstanding), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    #1;
    chk("mid_rst_ready", 32'(bus.alloc_ready), 1);
    chk("mid_rst_tag", 32'(bus.alloc_tag), 0);
    step(0, 0, 0, 1, 0, 4, 0);
    step(1, 8'h12, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rd_tag_ctrl.md
# rd_tag_ctrl

Tag allocator and completion scheduler for the read path of the transaction layer. It grants PCIe tags to outgoing memory-read requests and records the AXI ID and expected length for each tag. For every Read Completion header it looks up and updates the tag entry, then presents the AXI `rid`, `rresp` and `last` qualifiers to the R-channel driver. It frees a tag when its final completion arrives, or on timeout when that option is compiled in.

## Interface
- `NUM_TAGS`, 32: outstanding tags; power of 2, 2..256.
- `TAG_W`, `$clog2(NUM_TAGS)`: tag index width; derived, do not override.
- `ID_W`, 8: AXI ID width.
- `TICK_CYCLES`, 1024: age prescaler period in cycles; used only with the timeout option.

- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `alloc_valid`, in, 1: read request wants a tag.
- `alloc_id`, in, `ID_W`: AXI ARID of the request.
- `alloc_len_dw`, in, 10: request length in DW; 0 means 1024.
- `alloc_ready`, out, 1: a free tag exists.
- `alloc_tag`, out, `TAG_W`: granted tag; valid while `alloc_ready`=1.
- `cpl_valid`, in, 1: completion header available.
- `cpl_tag`, in, 10: completion tag field.
- `cpl_len_dw`, in, 10: completion payload length in DW; 0 means 1024.
- `cpl_status`, in, 3: completion status.
- `cpl_ready`, out, 1: completion header consumed.
- `sched_valid`, out, 1: qualifier entry valid.
- `sched_rid`, out, `ID_W`: AXI ID for this completion.
- `sched_rresp`, out, 2: AXI response code.
- `sched_last`, out, 1: final completion for the tag.
- `sched_ready`, in, 1: R driver accepts the entry.
- `err_unexp`, out, 1: one-cycle pulse on an unexpected completion.
- `outstanding`, out, `TAG_W+1`: number of busy tags.

## Operation
- Each table entry holds `busy`, `id[ID_W]` and `rem_dw[11]`.
- **Alloc:**
  - `alloc_tag` is the lowest-index entry with `busy`=0, computed combinationally from registered state.
  - `alloc_ready` = any free tag.
  - On fire (`alloc_valid` & `alloc_ready`): `busy` <= 1, `id` <= `alloc_id`, `rem_dw` <= len, where 0 maps to 1024.
- **Completion, on fire (`cpl_valid` & `cpl_ready`):**
  - **Unexpected case:** `cpl_tag` >= `NUM_TAGS`, or the entry is not busy.
    - The header is consumed and `err_unexp` pulses.
    - No sched entry is produced.
  - **Otherwise:**
    - `rem_new` = `rem_dw` − len, where `cpl_len_dw` 0 maps to 1024.
    - Overrun (len > `rem_dw`): treated as last, `rresp` = 2'b10.
  - **Status mapping:**
    - 3'b000 -> `rresp` 2'b00.
    - 3'b001 (UR) -> 2'b11.
    - Any other value -> 2'b10.
  - **Last:** `last` = (`rem_new` == 0) | (status != 0) | overrun.
  - If last: the entry is freed. Otherwise `rem_dw` <= `rem_new`.
- **Sched output:**
  - One registered stage holds `{rid, rresp, last}` with `sched_valid`.
  - `sched_valid` stays asserted until `sched_ready` is seen.
  - `cpl_ready` = (!`sched_valid` | `sched_ready`), further gated by expiry when timeout is enabled.
- **Outstanding count:** `outstanding` is updated every cycle by +alloc fire −free event.

## Timing
- **Reset values:**
  - `sched_valid`, `sched_rid`, `sched_rresp`, `sched_last`, `err_unexp` = 0.
  - `outstanding` = 0; every entry has `busy`=0.
  - `alloc_ready` = 1 and `alloc_tag` = 0 in the first cycle after reset.
- **Latency:** a completion fire in cycle N produces `sched_valid`=1 in N+1. Back-to-back completions sustain one per cycle while `sched_ready`=1.
- **Alloc and free in the same cycle:** both are applied. The freed tag becomes grantable from the next cycle only, and `outstanding` stays unchanged.
- **Table full:** `alloc_ready`=0; completions are still processed.
- **`sched_ready`=0:** `sched_*` outputs hold stable, and `cpl_ready`=0 from the next cycle.
- **Reset mid-operation:** every entry is cleared and the pending sched entry is dropped. Completions arriving after reset are treated as unexpected.

## Configuration
- `RD_TAG_TIMEOUT_EN` defined:
  - Each entry carries a 4-bit age.
  - A global prescaler pulses once every `TICK_CYCLES`; each pulse increments the age of every busy entry, saturating at 15.
  - Age resets to 0 on allocation and on every partial completion.
  - An entry with age = 15 is expired.
- Expiry has priority over completion:
  - While any entry is expired, `cpl_ready`=0.
  - When the sched stage is free, the lowest expired tag is emitted with `rresp` 2'b10 and `last` 1, using its stored `id`, and that tag is freed.
  - A late completion for a timed-out tag that has not been reallocated is treated as unexpected.
- `RD_TAG_TIMEOUT_EN` undefined: there is no age logic, `TICK_CYCLES` is ignored, and a tag stays busy until its final completion.

## Test plan
- **Reset then allocate:** reset, then 3 allocs (id 0x11/0x22/0x33, len 8) -> `alloc_tag` 0,1,2; `outstanding`=3.
- **Split completion:** for tag 1, send cpl len 4 then len 4, both status 0 -> two sched entries with rid 0x22, rresp 00, last 0 then 1; tag 1 is free afterwards and the next `alloc_tag` is 1.
- **Fill and recycle with backpressure:** fill all 32 tags -> `alloc_ready`=0. Then, with `sched_ready` held low, complete tag 5 -> `cpl_ready` drops after one entry; release `sched_ready` -> a following alloc grants tag 5.
- **Error completions:** UR on tag 2 with `rem_dw` 8 -> rresp 11, last 1, tag freed. A cpl for idle tag 7 -> `err_unexp` pulse, no sched entry. Tag 40 -> same response.
- **Overrun:** alloc len 2, then cpl len 4 -> rresp 10, last 1, tag freed.
- **Timeout (`RD_TAG_TIMEOUT_EN`, `TICK_CYCLES`=4):** alloc id 0x5A, no completion -> after 60 cycles, sched entry rid 0x5A, rresp 10, last 1, and `outstanding` returns to 0.
